// File: rtl/mac_requant_drain_pkg.sv
// Shared constants and the round/shift/clamp helper for int8 requantisation paths.
// Optional build macro RELU_EN narrows the clamp range to [0, QMAX].
package mac_requant_drain_pkg;

    localparam int N         = 8;
    localparam int SUM_WIDTH = (2 * N) + 4;
    localparam int M_WIDTH   = 16;
    localparam int SH_WIDTH  = 5;
    localparam int CNT_WIDTH = 16;

    localparam int S_WIDTH = SUM_WIDTH + 1;
    localparam int P_WIDTH = SUM_WIDTH + M_WIDTH + 2;
    localparam int R_WIDTH = P_WIDTH + 1;

    localparam int QMAX = 127;
    localparam int QMIN = -128;

    typedef struct packed {
        logic signed [N-1:0] q;
        logic                sat;
    } rq_t;

    // One extra bit of headroom so adding the rounding half can never overflow.
    function automatic rq_t round_shift_clamp(input logic signed [P_WIDTH-1:0] p,
                                              input logic [SH_WIDTH-1:0]       sh);
        logic signed [R_WIDTH-1:0] ext;
        logic signed [R_WIDTH-1:0] half;
        logic signed [R_WIDTH-1:0] r;
        logic signed [R_WIDTH-1:0] hi;
        logic signed [R_WIDTH-1:0] lo;
        rq_t                       res;

        ext  = R_WIDTH'(p);
        hi   = R_WIDTH'(QMAX);
        lo   = R_WIDTH'(QMIN);
        half = '0;
        if (sh != '0) begin
            half[sh - SH_WIDTH'(1)] = 1'b1;
        end
        r = (sh == '0) ? ext : ((ext + half) >>> sh);

        res.q   = r[N-1:0];
        res.sat = 1'b0;
`ifdef RELU_EN
        if (r > hi) begin
            res.q   = N'(QMAX);
            res.sat = 1'b1;
        end else if (r[R_WIDTH-1]) begin
            res.q   = '0;
        end
`else
        if (r > hi) begin
            res.q   = N'(QMAX);
            res.sat = 1'b1;
        end else if (r < lo) begin
            res.q   = N'(QMIN);
            res.sat = 1'b1;
        end
`endif
        return res;
    endfunction

endpackage

// File: rtl/requant_round_sat.sv
// Combinational final stage: rounding right shift of the scaled product, then int8 clamp.
// Clamp range follows RELU_EN through the shared package helper.
module requant_round_sat
    import mac_requant_drain_pkg::*;
(
    input  logic signed [P_WIDTH-1:0]  prod,
    input  logic        [SH_WIDTH-1:0] shift,
    output logic signed [N-1:0]        q,
    output logic                       sat
);

    rq_t res;

    assign res = round_shift_clamp(prod, shift);
    assign q   = res.q;
    assign sat = res.sat;

endmodule

// File: rtl/mac_requant_drain.sv
// Drain end of the MAC row: bias add, scale, round-shift, int8 saturate in a 3-stage pipe.
// Build with RELU_EN defined for a [0, 127] output range where only the upper clamp counts.
module mac_requant_drain
    import mac_requant_drain_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_load,
    input  logic signed [SUM_WIDTH-1:0] cfg_bias,
    input  logic        [M_WIDTH-1:0]   cfg_scale,
    input  logic        [SH_WIDTH-1:0]  cfg_shift,
    output logic                        cfg_err,
    input  logic                        acc_valid,
    output logic                        acc_ready,
    input  logic signed [SUM_WIDTH-1:0] acc_in,
    output logic                        q_valid,
    input  logic                        q_ready,
    output logic signed [N-1:0]         q_out,
    output logic                        busy,
    output logic        [CNT_WIDTH-1:0] sat_cnt,
    input  logic                        sat_clr
);

    logic signed [SUM_WIDTH-1:0] cur_bias;
    logic        [M_WIDTH-1:0]   cur_scale;
    logic        [SH_WIDTH-1:0]  cur_shift;

    logic                        s1_valid;
    logic signed [S_WIDTH-1:0]   s1_sum;
    logic                        s2_valid;
    logic signed [P_WIDTH-1:0]   s2_prod;

    logic                        advance;
    logic                        cfg_ok;
    logic signed [S_WIDTH-1:0]   sum_next;
    logic signed [P_WIDTH-1:0]   prod_next;
    logic signed [N-1:0]         rq_q;
    logic                        rq_sat;

    // The whole pipe moves in lockstep, gated only by the output register.
    assign advance   = !q_valid || q_ready;
    assign acc_ready = advance;
    assign busy      = s1_valid || s2_valid || q_valid;
    assign cfg_ok    = cfg_load && !busy && !acc_valid;

    assign sum_next  = S_WIDTH'(acc_in) + S_WIDTH'(cur_bias);
    assign prod_next = P_WIDTH'(s1_sum) * P_WIDTH'($signed({1'b0, cur_scale}));

    requant_round_sat u_round_sat (
        .prod  (s2_prod),
        .shift (cur_shift),
        .q     (rq_q),
        .sat   (rq_sat)
    );

    // Config only changes with an empty pipe, so every stage may read it live.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_bias  <= '0;
            cur_scale <= M_WIDTH'(1);
            cur_shift <= '0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= cfg_load && !cfg_ok;
            if (cfg_ok) begin
                cur_bias  <= cfg_bias;
                cur_scale <= cfg_scale;
                cur_shift <= cfg_shift;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s2_valid <= 1'b0;
            s2_prod  <= '0;
            q_valid  <= 1'b0;
            q_out    <= '0;
        end else if (advance) begin
            s1_valid <= acc_valid;
            s2_valid <= s1_valid;
            q_valid  <= s2_valid;
            if (acc_valid) begin
                s1_sum <= sum_next;
            end
            if (s1_valid) begin
                s2_prod <= prod_next;
            end
            if (s2_valid) begin
                q_out <= rq_q;
            end
        end
    end

    // Counts clamped beats as they land in the output register; sticks at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_cnt <= '0;
        end else if (sat_clr) begin
            sat_cnt <= '0;
        end else if (advance && s2_valid && rq_sat && (sat_cnt != '1)) begin
            sat_cnt <= sat_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_mac_requant_drain.sv
// Directed, table-driven bench for mac_requant_drain, plus hand sequences for stalls, config and reset.
// Expected values follow RELU_EN when the bench is built with it.
module tb_mac_requant_drain;

    logic               clk;
    logic               rst;
    logic               cfg_load;
    logic signed [19:0] cfg_bias;
    logic        [15:0] cfg_scale;
    logic        [4:0]  cfg_shift;
    logic               cfg_err;
    logic               acc_valid;
    logic               acc_ready;
    logic signed [19:0] acc_in;
    logic               q_valid;
    logic               q_ready;
    logic signed [7:0]  q_out;
    logic               busy;
    logic        [15:0] sat_cnt;
    logic               sat_clr;

    int pass_cnt  = 0;
    int check_cnt = 0;

    typedef struct {
        int bias;
        int scale;
        int shift;
        int acc;
        int exp_q;
        int exp_sat;
        int exp_q_relu;
        int exp_sat_relu;
    } vec_t;

    vec_t vecs[14];

    mac_requant_drain dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_load  (cfg_load),
        .cfg_bias  (cfg_bias),
        .cfg_scale (cfg_scale),
        .cfg_shift (cfg_shift),
        .cfg_err   (cfg_err),
        .acc_valid (acc_valid),
        .acc_ready (acc_ready),
        .acc_in    (acc_in),
        .q_valid   (q_valid),
        .q_ready   (q_ready),
        .q_out     (q_out),
        .busy      (busy),
        .sat_cnt   (sat_cnt),
        .sat_clr   (sat_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input longint actual, input longint expected);
        check_cnt++;
        if (actual == expected) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Called at a negedge with the pipe idle; returns at a negedge with the pipe idle again.
    task automatic apply_stimulus(input int acc, output int q, output int lat, output bit seen);
        acc_valid = 1'b1;
        acc_in    = acc[19:0];
        q_ready   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        acc_valid = 1'b0;
        acc_in    = '0;
        lat = 1;
        while (!q_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        seen = q_valid;
        q    = q_out;
        @(negedge clk);
    endtask

    task automatic load_cfg(input int b, input int s, input int sh);
        cfg_load  = 1'b1;
        cfg_bias  = b[19:0];
        cfg_scale = s[15:0];
        cfg_shift = sh[4:0];
        @(posedge clk);
        @(negedge clk);
        cfg_load = 1'b0;
        check_output("cfg_err_idle", cfg_err, 0);
    endtask

    initial begin
        int  q;
        int  lat;
        bit  seen;
        int  exp_sat;
        int  cur_b;
        int  cur_s;
        int  cur_sh;
        int  eq;
        int  sent;
        int  recv;
        int  cyc;
        int  extra;
        bit  stall_seen;

        vecs[0]  = '{0,   1,   0, 100,   100,  0, 100, 0};
        vecs[1]  = '{0,   1,   0, 1000,  127,  1, 127, 1};
        vecs[2]  = '{0,   1,   0, -1000, -128, 1, 0,   0};
        vecs[3]  = '{0,   3,   2, 5,     4,    0, 4,   0};
        vecs[4]  = '{0,   3,   2, -5,    -4,   0, 0,   0};
        vecs[5]  = '{0,   1,   2, -6,    -1,   0, 0,   0};
        vecs[6]  = '{-50, 1,   0, 30,    -20,  0, 0,   0};
        vecs[7]  = '{0,   256, 8, 127,   127,  0, 127, 0};
        vecs[8]  = '{0,   256, 8, 128,   127,  1, 127, 1};
        vecs[9]  = '{0,   256, 8, -128,  -128, 0, 0,   0};
        vecs[10] = '{0,   256, 8, -129,  -128, 1, 0,   0};
        vecs[11] = '{200, 1,   1, 53,    127,  0, 127, 0};
        vecs[12] = '{0,   1,   1, 3,     2,    0, 2,   0};
        vecs[13] = '{0,   1,   1, -3,    -1,   0, 0,   0};

        rst       = 1'b1;
        cfg_load  = 1'b0;
        cfg_bias  = '0;
        cfg_scale = '0;
        cfg_shift = '0;
        acc_valid = 1'b0;
        acc_in    = '0;
        q_ready   = 1'b1;
        sat_clr   = 1'b0;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);

        check_output("rst_q_valid", q_valid, 0);
        check_output("rst_q_out", q_out, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_acc_ready", acc_ready, 1);
        check_output("rst_sat_cnt", sat_cnt, 0);
        check_output("rst_cfg_err", cfg_err, 0);

        rst = 1'b1;
        @(negedge clk);

        exp_sat = 0;
        cur_b   = 0;
        cur_s   = 1;
        cur_sh  = 0;
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].bias != cur_b || vecs[i].scale != cur_s || vecs[i].shift != cur_sh) begin
                load_cfg(vecs[i].bias, vecs[i].scale, vecs[i].shift);
                cur_b  = vecs[i].bias;
                cur_s  = vecs[i].scale;
                cur_sh = vecs[i].shift;
            end
            apply_stimulus(vecs[i].acc, q, lat, seen);
`ifdef RELU_EN
            eq      = vecs[i].exp_q_relu;
            exp_sat = exp_sat + vecs[i].exp_sat_relu;
`else
            eq      = vecs[i].exp_q;
            exp_sat = exp_sat + vecs[i].exp_sat;
`endif
            check_output($sformatf("vec%0d_seen", i), seen, 1);
            check_output($sformatf("vec%0d_latency", i), lat, 3);
            check_output($sformatf("vec%0d_q_out", i), q, eq);
            check_output($sformatf("vec%0d_sat_cnt", i), sat_cnt, exp_sat);
        end

        // Back-pressure: five beats, downstream stalls for four cycles mid-stream.
        load_cfg(0, 1, 0);
        sent       = 0;
        recv       = 0;
        cyc        = 0;
        stall_seen = 1'b0;
        while (recv < 5 && cyc < 40) begin
            q_ready   = !(cyc >= 4 && cyc < 8);
            acc_valid = (sent < 5);
            acc_in    = 20'(sent + 1);
            #1;
            if (q_valid && !q_ready) begin
                stall_seen = 1'b1;
                check_output("bp_acc_ready_low", acc_ready, 0);
                check_output("bp_q_out_hold", q_out, recv + 1);
            end
            if (acc_valid && acc_ready) sent++;
            if (q_valid && q_ready) begin
                check_output("bp_order", q_out, recv + 1);
                recv++;
            end
            @(negedge clk);
            cyc++;
        end
        acc_valid = 1'b0;
        q_ready   = 1'b1;
        check_output("bp_sent", sent, 5);
        check_output("bp_recv", recv, 5);
        check_output("bp_stall_seen", stall_seen, 1);
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (q_valid) extra++;
        end
        check_output("bp_no_duplicate", extra, 0);

        // cfg_load while a beat is in flight is rejected and keeps the old scale.
        acc_valid = 1'b1;
        acc_in    = 20'sd10;
        @(posedge clk);
        @(negedge clk);
        acc_valid = 1'b0;
        cfg_load  = 1'b1;
        cfg_bias  = '0;
        cfg_scale = 16'd5;
        cfg_shift = '0;
        @(posedge clk);
        @(negedge clk);
        cfg_load = 1'b0;
        check_output("cfg_err_busy", cfg_err, 1);
        @(negedge clk);
        check_output("cfg_err_one_cycle", cfg_err, 0);
        check_output("cfg_busy_beat_valid", q_valid, 1);
        check_output("cfg_busy_beat_q", q_out, 10);
        @(negedge clk);
        apply_stimulus(7, q, lat, seen);
        check_output("cfg_old_scale_kept", q, 7);

        // cfg_load alongside acc_valid with an idle pipe is also rejected.
        cfg_load  = 1'b1;
        cfg_scale = 16'd5;
        acc_valid = 1'b1;
        acc_in    = 20'sd3;
        @(posedge clk);
        @(negedge clk);
        cfg_load  = 1'b0;
        acc_valid = 1'b0;
        check_output("cfg_err_acc_valid", cfg_err, 1);
        repeat (2) @(negedge clk);
        check_output("cfg_valid_beat_q", q_out, 3);
        @(negedge clk);

        // sat_clr wins over an increment landing on the same edge.
        acc_valid = 1'b1;
        acc_in    = 20'sd1000;
        @(posedge clk);
        @(negedge clk);
        acc_valid = 1'b0;
        @(negedge clk);
        sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        check_output("clr_beat_valid", q_valid, 1);
        check_output("clr_beat_q", q_out, 127);
        check_output("clr_priority", sat_cnt, 0);
        @(negedge clk);
        apply_stimulus(1000, q, lat, seen);
        check_output("sat_after_clr", sat_cnt, 1);

        // Asynchronous reset with a full, stalled pipe and non-default config.
        load_cfg(0, 2, 0);
        q_ready   = 1'b0;
        acc_valid = 1'b1;
        acc_in    = 20'sd1000;
        repeat (4) @(negedge clk);
        check_output("pre_rst_q_valid", q_valid, 1);
        check_output("pre_rst_sat_cnt", sat_cnt, 2);
        #2 rst = 1'b0;
        #1;
        check_output("async_rst_q_valid", q_valid, 0);
        check_output("async_rst_sat_cnt", sat_cnt, 0);
        check_output("async_rst_busy", busy, 0);
        check_output("async_rst_acc_ready", acc_ready, 1);
        check_output("async_rst_q_out", q_out, 0);
        acc_valid = 1'b0;
        @(negedge clk);
        rst     = 1'b1;
        q_ready = 1'b1;
        @(negedge clk);
        apply_stimulus(50, q, lat, seen);
        check_output("post_rst_cfg_default", q, 50);
        check_output("post_rst_latency", lat, 3);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/mac_requant_drain.md
Name: mac_requant_drain

Overview:
- Consumer end of the MAC chain: accepts SUM_WIDTH signed partial sums (mac_out of the last MAC in a row) over a valid/ready handshake.
- Adds a per-layer bias, rescales by a fixed-point multiplier and right shift with rounding, then saturates to int8.
- The int8 result feeds the next layer's xin stream.
- 3-stage pipeline with full back-pressure and a saturation event counter.

Parameters:
- N, 8: output activation width (signed).
- SUM_WIDTH, 20: accumulator input width, (2*N)+4.
- M_WIDTH, 16: unsigned scale multiplier width.
- SH_WIDTH, 5: shift amount width (0..31).
- CNT_WIDTH, 16: saturation counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cfg_load  in  1  load cfg_bias/cfg_scale/cfg_shift (pulse).
- cfg_bias  in  SUM_WIDTH  signed bias.
- cfg_scale  in  M_WIDTH  unsigned multiplier.
- cfg_shift  in  SH_WIDTH  right-shift amount.
- cfg_err  out  1  1-cycle pulse: cfg_load rejected.
- acc_valid  in  1  acc_in valid.
- acc_ready  out  1  block can accept.
- acc_in  in  SUM_WIDTH  signed accumulator.
- q_valid  out  1  q_out valid.
- q_ready  in  1  downstream accepts.
- q_out  out  N  signed saturated result.
- busy  out  1  any pipeline stage holds data.
- sat_cnt  out  CNT_WIDTH  count of clamped results.
- sat_clr  in  1  synchronous clear of sat_cnt.

Behaviour:
- Reset (rst=0, async): all stage valids 0, q_valid=0, q_out=0, busy=0, cfg_err=0, sat_cnt=0, acc_ready=1.
- Config reset values: bias=0, scale=1, shift=0.
- Transfer occurs when valid and ready are both high on a clock edge.
- advance = !q_valid || q_ready; acc_ready = advance (combinational). The whole pipe moves together or stalls together.
- Stalled stages hold data. q_out stays stable while q_valid && !q_ready.
- S1: s = acc_in + bias, SUM_WIDTH+1 signed, no overflow.
- S2: p = s * scale, scale zero-extended, signed product of SUM_WIDTH+M_WIDTH+2 bits.
- S3: if shift==0, r = p; else r = (p + (1 << (shift-1))) >>> shift (round half toward +inf). Clamp r to [-128, 127] to form q_out.
- Latency: accepted beat appears on q_valid exactly 3 cycles later with no stall. Throughput is 1 beat/cycle.
- sat_cnt increments when a clamped beat enters the output register. It saturates at all-ones, no wrap. sat_clr has priority over increment.
- busy = OR of S1/S2/output valids.
- cfg_load when busy=0: registers update next edge and apply to beats accepted after that edge.
- cfg_load when busy=1 or acc_valid=1: ignored, cfg_err pulses 1 cycle, config unchanged.
- Simultaneous advance-in and advance-out at the output: no bubble, no loss.
- Reset mid-stream: all in-flight beats discarded, config returns to reset values.

Optional Feature:
- RELU_EN defined: clamp range becomes [0, 127]. Negative r outputs 0 and does NOT count as saturation; only r>127 counts.
- RELU_EN undefined: range [-128, 127], both bounds count.

Decomposition:
- Shared package holds:
  - constants N, SUM_WIDTH, M_WIDTH, SH_WIDTH, QMAX=127, QMIN=-128;
  - a round-shift-clamp function reused by other requant paths.
- One natural sub-module: requant_round_sat (combinational S3 arithmetic), instantiated once and unit-testable alone.
- Pipeline registers and handshake stay in the top.

Test Plan:
- Identity, passthrough of 100: bias=0, scale=1, shift=0, acc_in=100 → q_out=100, 3 cycles after accept, sat_cnt=0.
- Clamp both sides: acc_in=1000 then -1000 → q_out=127 then -128, sat_cnt=2 (with RELU_EN: 127 then 0, sat_cnt=1).
- Rounding, scale=3 shift=2: acc 5 → 4; acc -5 → -4. With scale=1, shift=2: acc -6 → -1.
- Bias: bias=-50, scale=1, shift=0, acc_in=30 → -20.
- Back-pressure stream of 1,2,3,4,5 with q_ready low for 4 cycles mid-stream:
  - acc_ready drops;
  - q_out holds steady;
  - all five delivered in order, none duplicated.
- Config/reset corner cases:
  - cfg_load while busy → cfg_err=1 for one cycle, old scale still used;
  - rst low mid-stream → q_valid=0, sat_cnt=0 immediately, without waiting for a clock edge.
